// File: rtl/fu_wb_arbiter_pkg.sv
// Shared constants for the functional-unit writeback arbiter.
// FU indices, widths and the per-FU holding slot layout.
package fu_wb_arbiter_pkg;

  localparam int NFU = 5;
  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int SW  = 3;

  localparam int FU_ALU  = 0;
  localparam int FU_MEM  = 1;
  localparam int FU_MUL  = 2;
  localparam int FU_DIV  = 3;
  localparam int FU_JUMP = 4;

endpackage

// File: rtl/fu_wb_arbiter_if.sv
// FU result bus and register-file writeback bus.
// master = FU/issue side, slave = arbiter.
interface fu_wb_arbiter_if
  import fu_wb_arbiter_pkg::*;
#(
  parameter int NFU = fu_wb_arbiter_pkg::NFU
);

  logic [NFU-1:0]    fu_finish;
  logic [NFU*DW-1:0] fu_res;
  logic [NFU*AW-1:0] fu_rd;
  logic [NFU-1:0]    fu_we;
  logic [NFU-1:0]    fu_full;
  logic              wb_en;
  logic [AW-1:0]     wb_addr;
  logic [DW-1:0]     wb_data;
  logic [SW-1:0]     wb_src;
  logic              ovf_err;

  modport master (
    output fu_finish, fu_res, fu_rd, fu_we,
    input  fu_full, wb_en, wb_addr,
    input  wb_data, wb_src, ovf_err
  );

  modport slave (
    input  fu_finish, fu_res, fu_rd, fu_we,
    output fu_full, wb_en, wb_addr,
    output wb_data, wb_src, ovf_err
  );

endinterface

// File: rtl/fu_wb_arbiter_picker.sv
// Round-robin picker: lowest request at or above ptr,
// else lowest request overall.
module rr_picker #(
  parameter int N = 5,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [N-1:0] hi;
  logic [N-1:0] sel;

  always_comb begin
    hi  = '0;
    for (int i = 0; i < N; i++)
      hi[i] = req[i] && (i >= int'(ptr));
    sel = (|hi) ? hi : req;
    gnt = '0;
    idx = '0;
    // descending scan so the lowest set bit wins
    for (int i = N - 1; i >= 0; i--) begin
      if (sel[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
        idx    = W'(i);
      end
    end
    any = |req;
  end

endmodule

// File: rtl/fu_wb_arbiter.sv
// Writeback arbiter: one holding slot per FU, round-robin
// grant into registered register-file write port.
module fu_wb_arbiter
  import fu_wb_arbiter_pkg::*;
#(
  parameter int NFU = fu_wb_arbiter_pkg::NFU
) (
  input logic        clk,
  input logic        rst,
  fu_wb_arbiter_if.slave bus
);

  logic [NFU-1:0] vld;
  logic [DW-1:0]  data_q [NFU];
  logic [AW-1:0]  rd_q   [NFU];
  logic [SW-1:0]  last_q;
  logic [SW-1:0]  ptr;

  logic [DW-1:0]  res    [NFU];
  logic [AW-1:0]  rd_in  [NFU];
  logic [NFU-1:0] cap;
  logic [NFU-1:0] load;
  logic [NFU-1:0] gnt;
  logic [SW-1:0]  gidx;
  logic           any;
  logic           drop;

  always_comb begin
    for (int i = 0; i < NFU; i++) begin
      res[i]   = bus.fu_res[i*DW +: DW];
      rd_in[i] = bus.fu_rd[i*AW +: AW];
      cap[i]   = bus.fu_finish[i] & bus.fu_we[i]
               & (rd_in[i] != '0);
    end
  end

  assign ptr = (last_q == SW'(NFU - 1)) ? '0
             : last_q + 1'b1;

  rr_picker #(
    .N (NFU),
    .W (SW)
  ) u_pick (
    .req (vld),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gidx),
    .any (any)
  );

  // a slot being drained this cycle can accept a new result
  assign load        = cap & (~vld | gnt);
  assign drop        = |(cap & vld & ~gnt);
  assign bus.fu_full = vld & ~gnt;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NFU; i++) begin
      if (load[i]) begin
        data_q[i] <= res[i];
        rd_q[i]   <= rd_in[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld         <= '0;
      last_q      <= SW'(NFU - 1);
      bus.wb_en   <= 1'b0;
      bus.wb_addr <= '0;
      bus.wb_data <= '0;
      bus.wb_src  <= '0;
      bus.ovf_err <= 1'b0;
    end else begin
      vld       <= (vld & ~gnt) | load;
      bus.wb_en <= any;
      if (any) begin
        last_q      <= gidx;
        bus.wb_addr <= rd_q[gidx];
        bus.wb_data <= data_q[gidx];
        bus.wb_src  <= gidx;
      end
      if (drop)
        bus.ovf_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fu_wb_arbiter.sv
// Scoreboard bench for fu_wb_arbiter: directed scenarios
// plus random traffic against a queue-based reference model.
module tb_fu_wb_arbiter;
  import fu_wb_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fu_wb_arbiter_if #(.NFU(NFU)) bus ();

  fu_wb_arbiter #(.NFU(NFU)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    int          s;
  } wr_t;

  wr_t         sb[$];
  bit          m_vld  [NFU];
  logic [31:0] m_data [NFU];
  logic [4:0]  m_rd   [NFU];
  int          m_last;
  bit          exp_en;
  bit          exp_ovf;
  bit          m_live = 0;
  int          mg;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string n,
                     input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  // next pending FU in rotation after the last one served
  function automatic int pick();
    for (int k = 1; k <= NFU; k++) begin
      int j;
      j = (m_last + k) % NFU;
      if (m_vld[j]) return j;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      foreach (m_vld[i]) m_vld[i] = 0;
      m_last  = NFU - 1;
      exp_en  = 0;
      exp_ovf = 0;
      sb.delete();
      m_live  = 1;
    end else if (m_live) begin
      mg     = pick();
      exp_en = (mg >= 0);
      if (mg >= 0) begin
        sb.push_back('{m_rd[mg], m_data[mg], mg});
        m_vld[mg] = 0;
        m_last    = mg;
      end
      for (int i = 0; i < NFU; i++) begin
        if (bus.fu_finish[i] && bus.fu_we[i]
            && bus.fu_rd[i*5 +: 5] != 0) begin
          if (m_vld[i]) exp_ovf = 1;
          else begin
            m_vld[i]  = 1;
            m_data[i] = bus.fu_res[i*32 +: 32];
            m_rd[i]   = bus.fu_rd[i*5 +: 5];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      logic [NFU-1:0] ef;
      int g;
      wr_t w;
      g = pick();
      for (int i = 0; i < NFU; i++)
        ef[i] = m_vld[i] && (g != i);
      chk("wb_en", 64'(bus.wb_en), 64'(exp_en));
      chk("ovf_err", 64'(bus.ovf_err), 64'(exp_ovf));
      chk("fu_full", 64'(bus.fu_full), 64'(ef));
      if (bus.wb_en === 1'b1) begin
        if (sb.size() == 0) begin
          chk("sb_empty_write", 64'(1), 64'(0));
        end else begin
          w = sb.pop_front();
          chk("wb_addr", 64'(bus.wb_addr), 64'(w.a));
          chk("wb_data", 64'(bus.wb_data), 64'(w.d));
          chk("wb_src", 64'(bus.wb_src), 64'(w.s));
        end
      end
    end
  end

  task automatic fin(input int i, input bit we,
                     input logic [4:0] rd,
                     input logic [31:0] res);
    bus.fu_finish[i]      = 1'b1;
    bus.fu_we[i]          = we;
    bus.fu_rd[i*5 +: 5]   = rd;
    bus.fu_res[i*32 +: 32] = res;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    bus.fu_finish = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int exp_src [3];
    bus.fu_finish = '0;
    bus.fu_we     = '0;
    bus.fu_rd     = '0;
    bus.fu_res    = '0;

    // single uncontended ALU result
    do_reset();
    @(negedge clk);
    chk("rst_wb_data", 64'(bus.wb_data), 64'(0));
    chk("rst_wb_src", 64'(bus.wb_src), 64'(0));
    fin(FU_ALU, 1, 5, 32'h1234);
    step();
    step();
    @(negedge clk);
    chk("lat_en", 64'(bus.wb_en), 64'(1));
    chk("lat_addr", 64'(bus.wb_addr), 64'(5));
    chk("lat_data", 64'(bus.wb_data), 64'h1234);
    chk("lat_src", 64'(bus.wb_src), 64'(0));
    step();
    @(negedge clk);
    chk("lat_en_off", 64'(bus.wb_en), 64'(0));

    // three simultaneous finishes drain in index order
    do_reset();
    fin(FU_ALU, 1, 1, 32'hA1);
    fin(FU_MUL, 1, 2, 32'hA2);
    fin(FU_DIV, 1, 3, 32'hA3);
    step();
    @(negedge clk);
    chk("multi_full3_a", 64'(bus.fu_full[3]), 64'(1));
    exp_src = '{0, 2, 3};
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk);
      chk("multi_en", 64'(bus.wb_en), 64'(1));
      chk("multi_src", 64'(bus.wb_src), 64'(exp_src[k]));
      if (k == 0)
        chk("multi_full3_b", 64'(bus.fu_full[3]), 64'(1));
    end

    // ALU and JUMP kept busy alternate
    do_reset();
    for (int c = 0; c < 9; c++) begin
      fin(FU_ALU, 1, 10, 32'(c));
      fin(FU_JUMP, 1, 11, 32'(c + 100));
      step();
      @(negedge clk);
      if (c >= 1) begin
        chk("rr_en", 64'(bus.wb_en), 64'(1));
        chk("rr_src", 64'(bus.wb_src),
            64'((c % 2 == 1) ? 0 : 4));
      end
    end

    // discarded results
    do_reset();
    fin(FU_MEM, 1, 0, 32'hDEAD);
    step();
    fin(FU_MEM, 0, 7, 32'hBEEF);
    step();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("disc_en", 64'(bus.wb_en), 64'(0));
      chk("disc_full1", 64'(bus.fu_full[1]), 64'(0));
      chk("disc_ovf", 64'(bus.ovf_err), 64'(0));
      step();
    end

    // overflow while MUL waits behind ALU
    do_reset();
    fin(FU_ALU, 1, 4, 32'hA0);
    fin(FU_MUL, 1, 6, 32'hB0);
    step();
    fin(FU_MUL, 1, 6, 32'hB1);
    step();
    @(negedge clk);
    chk("ovf_set", 64'(bus.ovf_err), 64'(1));
    chk("ovf_src0", 64'(bus.wb_src), 64'(0));
    step();
    @(negedge clk);
    chk("ovf_mul_en", 64'(bus.wb_en), 64'(1));
    chk("ovf_mul_src", 64'(bus.wb_src), 64'(2));
    chk("ovf_mul_data", 64'(bus.wb_data), 64'hB0);
    step();
    @(negedge clk);
    chk("ovf_lost", 64'(bus.wb_en), 64'(0));

    // reset with pending slots
    fin(FU_ALU, 1, 1, 32'h11);
    fin(FU_MEM, 1, 2, 32'h22);
    fin(FU_MUL, 1, 3, 32'h33);
    step();
    do_reset();
    @(negedge clk);
    chk("rst_en", 64'(bus.wb_en), 64'(0));
    chk("rst_full", 64'(bus.fu_full), 64'(0));
    chk("rst_ovf", 64'(bus.ovf_err), 64'(0));
    for (int k = 0; k < 4; k++) begin
      step();
      @(negedge clk);
      chk("rst_quiet", 64'(bus.wb_en), 64'(0));
    end

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < NFU; i++) begin
        if ($urandom_range(0, 2) == 0)
          fin(i, $urandom_range(0, 3) != 0,
              5'($urandom_range(0, 31)), $urandom);
      end
      step();
    end
    rst = 1'b0;
    repeat (10) step();
    @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fu_wb_arbiter.md
FU_WB_ARBITER -- requirements
Module: fu_wb_arbiter

Interface
REQ-001 Parameter NFU, default 5, number of functional-unit requesters; index 0=ALU, 1=MEM, 2=MUL, 3=DIV, 4=JUMP.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 fu_finish  input  NFU  per-FU result-valid pulse, one cycle per result.
REQ-005 fu_res  input  NFU*32  per-FU result data; slice i = bits [32i+31:32i].
REQ-006 fu_rd  input  NFU*5  per-FU destination register; slice i = bits [5i+4:5i].
REQ-007 fu_we  input  NFU  per-FU "result writes register" qualifier.
REQ-008 fu_full  output  NFU  per-FU slot-occupied flag; issue logic SHALL NOT enable FU i while fu_full[i]=1.
REQ-009 wb_en  output  1  register-file write enable, registered.
REQ-010 wb_addr  output  5  register-file write address, registered.
REQ-011 wb_data  output  32  register-file write data, registered.
REQ-012 wb_src  output  3  index of the FU whose result is on wb_*, registered.
REQ-013 ovf_err  output  1  sticky overflow flag, registered.

Function
REQ-014 One single-entry holding slot per FU: valid bit, 32-bit data, 5-bit rd.
REQ-015 Capture: at an edge where fu_finish[i]=1, fu_we[i]=1 and fu_rd[i]!=0, slot i SHALL load res/rd and set valid.
REQ-016 Results with fu_we[i]=0 or fu_rd[i]=0 SHALL be discarded; no slot load, no grant, no error.
REQ-017 Arbitration: each cycle at most one valid slot is granted; round-robin starting at index (last_grant+1) mod NFU, wrapping from NFU-1 to 0.
REQ-018 last_grant SHALL update only on a grant; with no valid slots it holds.
REQ-019 On the edge ending a grant cycle: wb_en<=1, wb_addr<=slot rd, wb_data<=slot data, wb_src<=i, and slot i valid is cleared.
REQ-020 With no grant in a cycle, wb_en<=0 on the next edge; wb_addr/wb_data/wb_src hold their previous values.
REQ-021 Latency: finish sampled at edge E produces wb_en=1 no earlier than the cycle after edge E+1; an uncontended result sees exactly 2 edges from finish to visible write.
REQ-022 Simultaneous capture and grant of the same slot: the new result SHALL load (old one drains to wb_*); the slot remains valid.
REQ-023 fu_full[i] = slot i valid AND NOT (slot i granted this cycle); combinational from state plus grant.
REQ-024 Capture into a valid, non-granted slot: the new result SHALL be dropped, the slot keeps its old contents, and ovf_err is set until reset.
REQ-025 Multiple simultaneous finishes on different FUs SHALL all be captured in the same edge.
REQ-026 No combinational path from fu_finish/fu_res to wb_*.

Reset
REQ-027 On rst=1 at an edge: all slot valid bits=0; last_grant=NFU-1, so the first grant search starts at 0; wb_en=0, wb_addr=0, wb_data=0, wb_src=0, ovf_err=0.
REQ-028 Reset SHALL take priority over capture and grant in the same edge; in-flight slot contents are lost.

Structure
REQ-029 Shared package holds FU index constants (FU_ALU..FU_JUMP), NFU, data width 32, and register-address width 5.
REQ-030 The round-robin priority picker SHALL be a separate sub-module rr_picker: request vector, pointer in; one-hot grant and index out.
REQ-031 Datapath: slot registers and an NFU:1 grant-indexed mux feeding the wb_* registers.

Verification
REQ-032 Reset, then ALU finish rd=5 res=0x1234: after 2 edges, wb_en=1, wb_addr=5, wb_data=0x1234, wb_src=0; the next cycle wb_en=0.
REQ-033 ALU, MUL, DIV finish in one cycle with rd=1,2,3: writes on 3 consecutive cycles in order ALU, MUL, DIV; fu_full[3]=1 until DIV is granted.
REQ-034 Round-robin fairness: keep ALU and JUMP slots refilled every cycle; grants alternate 0,4,0,4; neither starves.
REQ-035 MEM finish with rd=0, then with fu_we=0: wb_en stays 0 and fu_full[1] stays 0.
REQ-036 Second MUL finish while the MUL slot is held by a contending ALU grant: ovf_err=1; the original MUL data is written; the second is lost.
REQ-037 rst asserted with 3 slots valid: the next cycle shows wb_en=0, fu_full=0, ovf_err=0, and no later writes.
